// File: rtl/cpu_pkg.sv
// Shared CPU definitions: decoded-instruction entry layout, queue sizing and
// small helpers used by the decode/issue instruction queue.
package cpu_pkg;

    localparam int QUE_DEPTH = 16;

    typedef logic [$clog2(QUE_DEPTH)-1:0] que_ptr_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic [30:0] ctrl;
        logic        is_delay_slot;
    } dec_entry_t;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/inst_queue.sv
// Circular instruction buffer between decode and issue: 2-wide push, 2-wide pop,
// full and predicted-jump flushes, plus the overflowI back-pressure flag.
module inst_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH  = QUE_DEPTH,
    parameter int DATA_W = $bits(dec_entry_t)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                push_valid,
    input  logic [DATA_W-1:0]         push_data0,
    input  logic [DATA_W-1:0]         push_data1,
    input  logic [1:0]                pop_cnt,
    input  logic                      stallI,
    input  logic                      flush_que,
    input  logic                      pred_flush_que,
    input  logic                      keep_head,
    output logic                      head0_valid,
    output logic [DATA_W-1:0]         head0_data,
    output logic                      head1_valid,
    output logic [DATA_W-1:0]         head1_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflowI,
    output logic                      push_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] head_ptr_r, tail_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_err_r;
    logic             head0_valid_r, head1_valid_r, overflow_r;

    logic [1:0]        push_n_s, pop_req_s, eff_pop_s;
    logic [CNT_W-1:0]  free_s;
    logic              push_ok_s;
    logic [PTR_W-1:0]  head_nxt_s, tail_nxt_s, head_plus1_s, tail_plus1_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic              err_nxt_s, wr0_en_s, wr1_en_s;
    logic [DATA_W-1:0] wr0_data_s;

    assign head_plus1_s = head_ptr_r + PTR_ONE;
    assign tail_plus1_s = tail_ptr_r + PTR_ONE;
    // A lone push_data1 (push_valid = 2'b10) still lands at the tail slot.
    assign wr0_data_s   = push_valid[0] ? push_data0 : push_data1;

    // Next-state computation: flush priority, space test, pop clamping.
    always_comb begin
        head_nxt_s  = head_ptr_r;
        tail_nxt_s  = tail_ptr_r;
        count_nxt_s = count_r;
        err_nxt_s   = push_err_r;
        wr0_en_s    = 1'b0;
        wr1_en_s    = 1'b0;
        push_n_s    = popcount2(push_valid);
        pop_req_s   = (pop_cnt == 2'd3) ? 2'd2 : pop_cnt;
        free_s      = CNT_DEPTH - count_r;
        push_ok_s   = ({{(CNT_W-2){1'b0}}, push_n_s} <= free_s);
        if (stallI) begin
            eff_pop_s = 2'd0;
        end else if (count_r < {{(CNT_W-2){1'b0}}, pop_req_s}) begin
            eff_pop_s = count_r[1:0];
        end else begin
            eff_pop_s = pop_req_s;
        end

        if (flush_que) begin
            head_nxt_s  = '0;
            tail_nxt_s  = '0;
            count_nxt_s = '0;
        end else if (pred_flush_que) begin
            // Keeping the head preserves the jr delay slot already queued.
            if (keep_head && (count_r != '0)) begin
                tail_nxt_s  = head_plus1_s;
                count_nxt_s = CNT_W'(1);
            end else begin
                tail_nxt_s  = head_ptr_r;
                count_nxt_s = '0;
            end
        end else begin
            head_nxt_s = head_ptr_r + PTR_W'(eff_pop_s);
            if (push_ok_s) begin
                wr0_en_s    = (push_n_s != 2'd0);
                wr1_en_s    = (push_n_s == 2'd2);
                tail_nxt_s  = tail_ptr_r + PTR_W'(push_n_s);
                count_nxt_s = count_r + CNT_W'(push_n_s) - CNT_W'(eff_pop_s);
            end else begin
                err_nxt_s   = 1'b1;
                count_nxt_s = count_r - CNT_W'(eff_pop_s);
            end
        end
    end

    // Pointer, occupancy and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_ptr_r    <= '0;
            tail_ptr_r    <= '0;
            count_r       <= '0;
            push_err_r    <= 1'b0;
            head0_valid_r <= 1'b0;
            head1_valid_r <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            head_ptr_r    <= head_nxt_s;
            tail_ptr_r    <= tail_nxt_s;
            count_r       <= count_nxt_s;
            push_err_r    <= err_nxt_s;
            head0_valid_r <= (count_nxt_s != '0);
            head1_valid_r <= (count_nxt_s >= CNT_W'(2));
            // Four free slots cover one decode pair still in flight behind the stall.
            overflow_r    <= ((CNT_DEPTH - count_nxt_s) < CNT_W'(4));
        end
    end

    // Entry storage; contents need no reset since validity comes from count.
    always_ff @(posedge clk) begin
        if (wr0_en_s) begin
            mem[tail_ptr_r] <= wr0_data_s;
        end
        if (wr1_en_s) begin
            mem[tail_plus1_s] <= push_data1;
        end
    end

    assign head0_valid = head0_valid_r;
    assign head1_valid = head1_valid_r;
    assign head0_data  = mem[head_ptr_r];
    assign head1_data  = mem[head_plus1_s];
    assign count       = count_r;
    assign overflowI   = overflow_r;
    assign push_err    = push_err_r;

endmodule

// File: tb/tb_inst_queue.sv
// Directed, table-driven bench for inst_queue (DEPTH 16, DATA_W 96).
module tb_inst_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  push_valid;
    logic [95:0] push_data0, push_data1;
    logic [1:0]  pop_cnt;
    logic        stallI, flush_que, pred_flush_que, keep_head;
    logic        head0_valid, head1_valid, overflowI, push_err;
    logic [95:0] head0_data, head1_data;
    logic [4:0]  count;

    int checks = 0;
    int errors = 0;

    inst_queue #(.DEPTH(16), .DATA_W(96)) dut (
        .clk(clk), .reset(reset),
        .push_valid(push_valid), .push_data0(push_data0), .push_data1(push_data1),
        .pop_cnt(pop_cnt), .stallI(stallI), .flush_que(flush_que),
        .pred_flush_que(pred_flush_que), .keep_head(keep_head),
        .head0_valid(head0_valid), .head0_data(head0_data),
        .head1_valid(head1_valid), .head1_data(head1_data),
        .count(count), .overflowI(overflowI), .push_err(push_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] pv;
        int         t0, t1;
        logic [1:0] pop;
        logic       st, fl, pf, kh;
        int         ec, e0, e1;
        logic       eo, ee;
    } vec_t;

    vec_t vecs [32];

    function automatic logic [95:0] tag(input int t);
        logic [31:0] v;
        v = 32'(t);
        return {v, v ^ 32'hA5A5A5A5, ~v};
    endfunction

    function automatic vec_t mk(input logic [1:0] pv, input int t0, input int t1,
                                input logic [1:0] pop, input logic st, input logic fl,
                                input logic pf, input logic kh, input int ec,
                                input int e0, input int e1, input logic eo, input logic ee);
        vec_t v;
        v.pv = pv; v.t0 = t0; v.t1 = t1; v.pop = pop;
        v.st = st; v.fl = fl; v.pf = pf; v.kh = kh;
        v.ec = ec; v.e0 = e0; v.e1 = e1; v.eo = eo; v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] pv, input int t0, input int t1, input logic [1:0] pop,
                         input logic st, input logic fl, input logic pf, input logic kh);
        push_valid = pv; push_data0 = tag(t0); push_data1 = tag(t1);
        pop_cnt = pop; stallI = st; flush_que = fl; pred_flush_que = pf; keep_head = kh;
    endtask

    initial begin
        //          pv    t0  t1 pop   st fl pf kh  cnt h0  h1 ovf err
        vecs[0]  = mk(2'b11,  1,  2, 2'd0, 0, 0, 0, 0,  2,  1,  2, 0, 0);
        vecs[1]  = mk(2'b11,  3,  4, 2'd0, 0, 0, 0, 0,  4,  1,  2, 0, 0);
        vecs[2]  = mk(2'b11,  5,  6, 2'd0, 0, 0, 0, 0,  6,  1,  2, 0, 0);
        vecs[3]  = mk(2'b11,  7,  8, 2'd0, 0, 0, 0, 0,  8,  1,  2, 0, 0);
        vecs[4]  = mk(2'b11,  9, 10, 2'd0, 0, 0, 0, 0, 10,  1,  2, 0, 0);
        vecs[5]  = mk(2'b11, 11, 12, 2'd0, 0, 0, 0, 0, 12,  1,  2, 0, 0);
        vecs[6]  = mk(2'b01, 13,  0, 2'd0, 0, 0, 0, 0, 13,  1,  2, 1, 0);
        vecs[7]  = mk(2'b10, 99, 14, 2'd0, 0, 0, 0, 0, 14,  1,  2, 1, 0);
        vecs[8]  = mk(2'b01, 15,  0, 2'd0, 0, 0, 0, 0, 15,  1,  2, 1, 0);
        vecs[9]  = mk(2'b11, 16, 17, 2'd2, 0, 0, 0, 0, 13,  3,  4, 1, 1);
        vecs[10] = mk(2'b00,  0,  0, 2'd2, 1, 0, 0, 0, 13,  3,  4, 1, 1);
        vecs[11] = mk(2'b00,  0,  0, 2'd3, 0, 0, 0, 0, 11,  5,  6, 0, 1);
        vecs[12] = mk(2'b11, 18, 19, 2'd2, 0, 0, 0, 0, 11,  7,  8, 0, 1);
        vecs[13] = mk(2'b00,  0,  0, 2'd2, 0, 0, 0, 0,  9,  9, 10, 0, 1);
        vecs[14] = mk(2'b00,  0,  0, 2'd2, 0, 0, 0, 0,  7, 11, 12, 0, 1);
        vecs[15] = mk(2'b00,  0,  0, 2'd2, 0, 0, 0, 0,  5, 13, 14, 0, 1);
        vecs[16] = mk(2'b00,  0,  0, 2'd2, 0, 0, 0, 0,  3, 15, 18, 0, 1);
        vecs[17] = mk(2'b00,  0,  0, 2'd1, 0, 0, 0, 0,  2, 18, 19, 0, 1);
        vecs[18] = mk(2'b00,  0,  0, 2'd2, 0, 0, 0, 0,  0,  0,  0, 0, 1);
        vecs[19] = mk(2'b01, 20,  0, 2'd2, 0, 0, 0, 0,  1, 20,  0, 0, 1);
        vecs[20] = mk(2'b11, 21, 22, 2'd2, 0, 0, 0, 0,  2, 21, 22, 0, 1);
        vecs[21] = mk(2'b11, 23, 24, 2'd0, 0, 0, 0, 0,  4, 21, 22, 0, 1);
        vecs[22] = mk(2'b01, 25,  0, 2'd0, 0, 0, 0, 0,  5, 21, 22, 0, 1);
        vecs[23] = mk(2'b11, 26, 27, 2'd2, 0, 1, 1, 0,  0,  0,  0, 0, 1);
        vecs[24] = mk(2'b11, 28, 29, 2'd0, 0, 0, 0, 0,  2, 28, 29, 0, 1);
        vecs[25] = mk(2'b01, 30,  0, 2'd0, 0, 0, 0, 0,  3, 28, 29, 0, 1);
        vecs[26] = mk(2'b11, 31, 32, 2'd2, 0, 0, 1, 1,  1, 28,  0, 0, 1);
        vecs[27] = mk(2'b11, 33, 34, 2'd0, 0, 0, 0, 0,  3, 28, 33, 0, 1);
        vecs[28] = mk(2'b00,  0,  0, 2'd0, 0, 0, 1, 0,  0,  0,  0, 0, 1);
        vecs[29] = mk(2'b00,  0,  0, 2'd0, 0, 0, 1, 1,  0,  0,  0, 0, 1);
        vecs[30] = mk(2'b01, 35,  0, 2'd0, 0, 0, 0, 0,  1, 35,  0, 0, 1);
        vecs[31] = mk(2'b00,  0,  0, 2'd2, 0, 0, 0, 0,  0,  0,  0, 0, 1);

        // Reset held with pushes requested: nothing may be accepted.
        reset = 1'b0;
        drive(2'b11, 77, 78, 2'd0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive(2'b00, 0, 0, 2'd0, 0, 0, 0, 0);
        #1;
        chk("rst_count", -1, 96'(count), 96'(0));
        chk("rst_h0v", -1, 96'(head0_valid), 96'(0));
        chk("rst_ovf", -1, 96'(overflowI), 96'(0));
        chk("rst_err", -1, 96'(push_err), 96'(0));

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive(vecs[i].pv, vecs[i].t0, vecs[i].t1, vecs[i].pop,
                  vecs[i].st, vecs[i].fl, vecs[i].pf, vecs[i].kh);
            @(posedge clk);
            #1;
            chk("count", i, 96'(count), 96'(vecs[i].ec));
            chk("head0_valid", i, 96'(head0_valid), 96'(vecs[i].ec >= 1));
            chk("head1_valid", i, 96'(head1_valid), 96'(vecs[i].ec >= 2));
            chk("overflowI", i, 96'(overflowI), 96'(vecs[i].eo));
            chk("push_err", i, 96'(push_err), 96'(vecs[i].ee));
            if (vecs[i].ec >= 1) chk("head0_data", i, head0_data, tag(vecs[i].e0));
            if (vecs[i].ec >= 2) chk("head1_data", i, head1_data, tag(vecs[i].e1));
        end

        // Push is not visible before the edge that accepts it.
        @(negedge clk);
        drive(2'b11, 40, 41, 2'd0, 0, 0, 0, 0);
        #1;
        chk("no_bypass", 100, 96'(head0_valid), 96'(0));
        @(posedge clk);
        #1;
        chk("seq_count", 100, 96'(count), 96'(2));
        chk("seq_h0", 100, head0_data, tag(40));

        // Asynchronous reset mid-cycle clears the sticky error and occupancy.
        @(negedge clk);
        drive(2'b00, 0, 0, 2'd0, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("async_count", 101, 96'(count), 96'(0));
        chk("async_err", 101, 96'(push_err), 96'(0));
        chk("async_h0v", 101, 96'(head0_valid), 96'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_count", 102, 96'(count), 96'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
